// File: rtl/neuron_pkg.sv
// Shared types and helpers for the conditioned output neuron and its learning synapse.
package neuron_pkg;

    localparam int DEF_W_WIDTH   = 12;
    localparam int DEF_ACC_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INTEG   = 2'd1,
        FIRE    = 2'd2,
        REFRACT = 2'd3
    } neuron_state_t;

    // Unsigned add clamped to max_val; callers zero-extend their operands to 32 bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/hebbian_synapse.sv
// Plastic synapse: a pre spike opens a coincidence window, and a post spike inside it
// (or in the same cycle) bumps the weight once.
module hebbian_synapse
    import neuron_pkg::*;
#(
    parameter int                 W_WIDTH = DEF_W_WIDTH,
    parameter int                 WINDOW  = 104000,
    parameter logic [W_WIDTH-1:0] INIT    = '0,
    parameter logic [W_WIDTH-1:0] STEP    = W_WIDTH'(256)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pre_edge,
    input  logic               post_edge,
    input  logic               learn_en,
    output logic [W_WIDTH-1:0] weight
);

    localparam int          WIN_W = $clog2(WINDOW + 1);
    localparam logic [31:0] W_MAX = 32'((1 << W_WIDTH) - 1);

    logic [WIN_W-1:0] window;
    logic             coincident;

    assign coincident = post_edge && (pre_edge || (window != '0));

    // A learning event closes the window so one bell spike yields at most one increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight <= INIT;
            window <= '0;
        end else if (coincident && learn_en) begin
            weight <= W_WIDTH'(sat_add(32'(weight), 32'(STEP), W_MAX));
            window <= '0;
        end else if (pre_edge) begin
            window <= WIN_W'(WINDOW);
        end else if (window != '0) begin
            window <= window - 1'b1;
        end
    end

endmodule

// File: rtl/pavlov_output_neuron.sv
// Leaky integrate-and-fire neuron fed by the food (S1, fixed) and bell (S2, learned)
// detector lines; fires once at threshold and then stays refractory.
module pavlov_output_neuron
    import neuron_pkg::*;
#(
    parameter int                   W_WIDTH      = DEF_W_WIDTH,
    parameter int                   ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter logic [ACC_WIDTH-1:0] THRESHOLD    = ACC_WIDTH'(4000),
    parameter int                   LEAK_PERIOD  = 1024,
    parameter int                   LEAK_SHIFT   = 4,
    parameter int                   REFRACTORY   = 10400,
    parameter int                   COINC_WINDOW = 104000,
    parameter logic [W_WIDTH-1:0]   S1_INIT      = W_WIDTH'(12'hFFF),
    parameter logic [W_WIDTH-1:0]   S2_INIT      = '0,
    parameter logic [W_WIDTH-1:0]   LEARN_STEP   = W_WIDTH'(256)
) (
    input  logic                 CLK104MHZ,
    input  logic                 CPU_RESETN,
    input  logic                 N1S1_IN,
    input  logic                 N2S2_IN,
    input  logic                 learn_en,
    output logic                 fire_out,
    output logic [ACC_WIDTH-1:0] membrane,
    output logic [W_WIDTH-1:0]   s1_weight,
    output logic [W_WIDTH-1:0]   s2_weight,
    output logic [1:0]           state
);

    localparam int          LEAK_W  = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int          REFR_W  = (REFRACTORY > 1) ? $clog2(REFRACTORY) : 1;
    localparam logic [31:0] ACC_MAX = 32'((1 << ACC_WIDTH) - 1);

    logic                 n1_q, n2_q, e1_q, e2_q;
    logic [LEAK_W-1:0]    leak_cnt;
    logic                 leak_tick;
    logic [REFR_W-1:0]    refr_cnt;
    logic [ACC_WIDTH-1:0] contrib, leaked, integrated, membrane_nxt;
    neuron_state_t        cur_state, nxt_state;

    // Edge pulses are registered, so integration lands one cycle after the edge is sampled.
    always_ff @(posedge CLK104MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            n1_q <= 1'b0;
            n2_q <= 1'b0;
            e1_q <= 1'b0;
            e2_q <= 1'b0;
        end else begin
            n1_q <= N1S1_IN;
            n2_q <= N2S2_IN;
            e1_q <= N1S1_IN & ~n1_q;
            e2_q <= N2S2_IN & ~n2_q;
        end
    end

    always_ff @(posedge CLK104MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            s1_weight <= S1_INIT;
        end else begin
            s1_weight <= s1_weight;
        end
    end

    hebbian_synapse #(
        .W_WIDTH (W_WIDTH),
        .WINDOW  (COINC_WINDOW),
        .INIT    (S2_INIT),
        .STEP    (LEARN_STEP)
    ) u_s2_synapse (
        .clk       (CLK104MHZ),
        .rst_n     (CPU_RESETN),
        .pre_edge  (e2_q),
        .post_edge (e1_q),
        .learn_en  (learn_en),
        .weight    (s2_weight)
    );

    assign leak_tick  = (leak_cnt == LEAK_W'(LEAK_PERIOD - 1));
    assign contrib    = (e1_q ? ACC_WIDTH'(s1_weight) : '0) + (e2_q ? ACC_WIDTH'(s2_weight) : '0);
    assign leaked     = leak_tick ? (membrane - (membrane >> LEAK_SHIFT)) : membrane;
    assign integrated = ACC_WIDTH'(sat_add(32'(leaked), 32'(contrib), ACC_MAX));

    always_comb begin
        nxt_state    = cur_state;
        membrane_nxt = membrane;
        case (cur_state)
            IDLE: begin
                membrane_nxt = integrated;
                if (contrib != '0) nxt_state = INTEG;
            end
            INTEG: begin
                membrane_nxt = integrated;
                if (membrane >= THRESHOLD) nxt_state = FIRE;
                else if (membrane == '0)   nxt_state = IDLE;
            end
            FIRE: begin
                membrane_nxt = '0;
                nxt_state    = REFRACT;
            end
            REFRACT: begin
                if (refr_cnt == REFR_W'(REFRACTORY - 1)) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK104MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cur_state <= IDLE;
            membrane  <= '0;
            leak_cnt  <= '0;
            refr_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            membrane  <= membrane_nxt;
            leak_cnt  <= leak_tick ? '0 : leak_cnt + 1'b1;
            refr_cnt  <= (cur_state == REFRACT && nxt_state == REFRACT) ? refr_cnt + 1'b1 : '0;
        end
    end

    assign state    = cur_state;
    assign fire_out = (cur_state == FIRE);

endmodule

// File: tb/tb_pavlov_output_neuron.sv
// Bench for pavlov_output_neuron: two instances (food weight FFF and 400) share stimulus and
// are checked every cycle against a behavioural model, plus directed literal expectations.
module tb_pavlov_output_neuron;

    localparam int LP = 16;
    localparam int RP = 8;
    localparam int CW = 20;

    logic        clk;
    logic        rst_n;
    logic        n1, n2, learn_en;
    logic        fire_a, fire_b;
    logic [15:0] mem_a, mem_b;
    logic [11:0] s1_a, s1_b, s2_a, s2_b;
    logic [1:0]  st_a, st_b;

    int total = 0;
    int bad   = 0;

    pavlov_output_neuron #(.LEAK_PERIOD(LP), .REFRACTORY(RP), .COINC_WINDOW(CW)) u_dut (
        .CLK104MHZ (clk), .CPU_RESETN (rst_n), .N1S1_IN (n1), .N2S2_IN (n2),
        .learn_en (learn_en), .fire_out (fire_a), .membrane (mem_a),
        .s1_weight (s1_a), .s2_weight (s2_a), .state (st_a)
    );

    pavlov_output_neuron #(.LEAK_PERIOD(LP), .REFRACTORY(RP), .COINC_WINDOW(CW),
                           .S1_INIT(12'h400)) u_leak (
        .CLK104MHZ (clk), .CPU_RESETN (rst_n), .N1S1_IN (n1), .N2S2_IN (n2),
        .learn_en (learn_en), .fire_out (fire_b), .membrane (mem_b),
        .s1_weight (s1_b), .s2_weight (s2_b), .state (st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phases 0..3 are quiet/charging/firing/recovering.
    int s1v[2] = '{4095, 1024};
    int m_mem[2], m_st[2], m_rl[2];
    int m_s2, m_tn2, m_t;
    bit m_nv, p1, p2, pe1, pe2;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mem[i] = 0; m_st[i] = 0; m_rl[i] = 0;
        end
        m_s2 = 0; m_tn2 = 0; m_t = 0; m_nv = 0;
        p1 = 0; p2 = 0; pe1 = 0; pe2 = 0;
    endtask

    task automatic model_step();
        bit e1, e2, le, tick, open;
        int now, s2_old, contrib, lv, nst;
        e1 = pe1; e2 = pe2; le = learn_en;
        pe1 = n1 && !p1; pe2 = n2 && !p2;
        p1 = n1; p2 = n2;
        now  = m_t;
        tick = (now % LP) == LP - 1;
        m_t++;
        open   = m_nv && (now - m_tn2 <= CW);
        s2_old = m_s2;
        if (e1 && le && (e2 || open)) begin
            m_s2 = (m_s2 + 256 > 4095) ? 4095 : m_s2 + 256;
            m_nv = 0;
        end else if (e2) begin
            m_nv  = 1;
            m_tn2 = now;
        end
        for (int i = 0; i < 2; i++) begin
            contrib = (e1 ? s1v[i] : 0) + (e2 ? s2_old : 0);
            if (m_st[i] <= 1) begin
                nst = m_st[i];
                if (m_st[i] == 0 && contrib != 0) nst = 1;
                if (m_st[i] == 1) begin
                    if (m_mem[i] >= 4000)   nst = 2;
                    else if (m_mem[i] == 0) nst = 0;
                end
                lv = tick ? m_mem[i] - (m_mem[i] >> 4) : m_mem[i];
                lv = lv + contrib;
                m_mem[i] = (lv > 65535) ? 65535 : lv;
                m_st[i]  = nst;
            end else if (m_st[i] == 2) begin
                m_mem[i] = 0; m_st[i] = 3; m_rl[i] = RP;
            end else begin
                m_rl[i]--;
                if (m_rl[i] == 0) m_st[i] = 0;
            end
        end
    endtask

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check("mdl_fire_a", 32'(fire_a), 32'(m_st[0] == 2));
        check("mdl_mem_a",  32'(mem_a),  32'(m_mem[0]));
        check("mdl_st_a",   32'(st_a),   32'(m_st[0]));
        check("mdl_s1_a",   32'(s1_a),   32'h0FFF);
        check("mdl_s2_a",   32'(s2_a),   32'(m_s2));
        check("mdl_fire_b", 32'(fire_b), 32'(m_st[1] == 2));
        check("mdl_mem_b",  32'(mem_b),  32'(m_mem[1]));
        check("mdl_st_b",   32'(st_b),   32'(m_st[1]));
        check("mdl_s2_b",   32'(s2_b),   32'(m_s2));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (st_a != 2'd0 && n < 60) begin
            step(); n++;
        end
        check(name, 32'(st_a), 32'd0);
    endtask

    // Bell edge, then food edge gap cycles later; returns one cycle after the food edge is sampled.
    task automatic condition(input int gap);
        n2 = 1'b1; step(); n2 = 1'b0;
        repeat (gap - 1) step();
        n1 = 1'b1; step(); n1 = 1'b0;
        step();
    endtask

    initial begin
        int chg, v1, v2, fires, prev;
        rst_n = 1'b0; n1 = 1'b0; n2 = 1'b0; learn_en = 1'b0;
        step(); step();
        check("rst_mem", 32'(mem_a), 32'd0);
        check("rst_st", 32'(st_a), 32'd0);
        check("rst_fire", 32'(fire_a), 32'd0);
        check("rst_s1", 32'(s1_a), 32'hFFF);
        check("rst_s2", 32'(s2_a), 32'h000);
        rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_mem", 32'(mem_a), 32'd0);
        check("post_rst_st", 32'(st_a), 32'd0);

        // Single food spike: integrate, fire one cycle, refractory, no integration meanwhile.
        n1 = 1'b1; step(); n1 = 1'b0;
        step();
        check("n1_mem", 32'(mem_a), 32'd4095);
        check("n1_integ", 32'(st_a), 32'd1);
        step();
        check("n1_fire", 32'(fire_a), 32'd1);
        check("n1_fire_st", 32'(st_a), 32'd2);
        step();
        check("n1_fire_end", 32'(fire_a), 32'd0);
        check("n1_cleared", 32'(mem_a), 32'd0);
        for (int i = 0; i < RP; i++) begin
            check("refract_st", 32'(st_a), 32'd3);
            check("refract_mem", 32'(mem_a), 32'd0);
            if (i == 1) n1 = 1'b1;
            if (i == 3) n1 = 1'b0;
            step();
        end
        check("refract_done", 32'(st_a), 32'd0);
        check("refract_mem_end", 32'(mem_a), 32'd0);

        // Leak on the 0x400 instance.
        do_reset();
        n1 = 1'b1; step(); n1 = 1'b0;
        step();
        check("leak_load", 32'(mem_b), 32'd1024);
        chg = 0; v1 = 0; v2 = 0; fires = 0; prev = 1024;
        for (int i = 0; i < 40; i++) begin
            step();
            if (fire_b) fires++;
            if (mem_b != 16'(prev)) begin
                if (chg == 0) v1 = mem_b;
                if (chg == 1) v2 = mem_b;
                chg++;
                prev = mem_b;
            end
        end
        check("leak_ticks_seen", 32'(chg >= 2), 32'd1);
        check("leak_first", 32'(v1), 32'd960);
        check("leak_second", 32'(v2), 32'd900);
        check("leak_no_fire", 32'(fires), 32'd0);

        // Bell alone with zero weight does nothing.
        do_reset();
        n2 = 1'b1; step(); n2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bell0_mem", 32'(mem_a), 32'd0);
            check("bell0_st", 32'(st_a), 32'd0);
            check("bell0_fire", 32'(fire_a), 32'd0);
        end

        // Conditioning.
        learn_en = 1'b1;
        condition(5);
        check("learn_first", 32'(s2_a), 32'h100);
        repeat (14) step();
        condition(25);
        check("learn_late", 32'(s2_a), 32'h100);
        repeat (14) step();
        learn_en = 1'b0;
        condition(5);
        check("learn_disabled", 32'(s2_a), 32'h100);
        repeat (14) step();
        learn_en = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            condition(5);
            check("learn_iter", 32'(s2_a), (i * 256 > 4095) ? 32'hFFF : 32'(i * 256));
            repeat (14) step();
        end
        check("learn_clamp", 32'(s2_a), 32'hFFF);

        // Conditioned response: bell alone fires.
        wait_idle("idle_before_bell");
        n2 = 1'b1; step(); n2 = 1'b0;
        step();
        check("bell_mem", 32'(mem_a), 32'd4095);
        step();
        check("bell_fire", 32'(fire_a), 32'd1);
        repeat (12) step();

        // Simultaneous edges, then reset during refractory.
        wait_idle("idle_before_both");
        n1 = 1'b1; n2 = 1'b1; step(); n1 = 1'b0; n2 = 1'b0;
        step();
        check("both_mem", 32'(mem_a), 32'd8190);
        fires = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (fire_a) fires++;
        end
        check("both_single_fire", 32'(fires), 32'd1);
        check("both_refract", 32'(st_a), 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_rst_st", 32'(st_a), 32'd0);
        check("async_rst_mem", 32'(mem_a), 32'd0);
        check("async_rst_s2", 32'(s2_a), 32'd0);
        step();
        rst_n = 1'b1;

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            n1 = ($urandom_range(0, 5) == 0);
            n2 = ($urandom_range(0, 4) == 0);
            learn_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pavlov_output_neuron.md
Name: pavlov_output_neuron

Overview:
- Post-synaptic integrate-and-fire neuron at the receiving end of the two detector spike lines (N1S1 "sight of food", N2S2 "ring of a bell").
- Adds a per-synapse weight to a membrane accumulator on each input spike, leaks the membrane periodically, and emits a one-cycle fire pulse at threshold, followed by a refractory period.
- S2 weight learns Hebbian-style when a bell spike precedes or coincides with a food spike, implementing classical conditioning.

Parameters:
- W_WIDTH, 12, synapse weight width
- ACC_WIDTH, 16, membrane accumulator width
- THRESHOLD, 16'd4000, fire threshold; fire when membrane >= THRESHOLD
- LEAK_PERIOD, 1024, cycles between leak steps
- LEAK_SHIFT, 4, leak amount = membrane >> LEAK_SHIFT
- REFRACTORY, 10400, refractory length in cycles (100 us at 104 MHz)
- COINC_WINDOW, 104000, learning window in cycles after an N2 spike
- S1_INIT, 12'hFFF, reset value of s1_weight (fixed; never learns)
- S2_INIT, 12'h000, reset value of s2_weight
- LEARN_STEP, 12'd256, S2 increment per learning event

Ports:
- CLK104MHZ  in  1  system clock
- CPU_RESETN  in  1  asynchronous active-low reset
- N1S1_IN  in  1  food detector enable, synchronous to CLK104MHZ
- N2S2_IN  in  1  bell detector enable, synchronous to CLK104MHZ
- learn_en  in  1  enables S2 weight updates
- fire_out  out  1  one-cycle fire pulse
- membrane  out  ACC_WIDTH  current membrane value
- s1_weight  out  W_WIDTH  current S1 weight
- s2_weight  out  W_WIDTH  current S2 weight
- state  out  2  FSM state: IDLE=0, INTEG=1, FIRE=2, REFRACT=3

Behaviour:
- Reset (asynchronous, CPU_RESETN=0):
  - fire_out=0, membrane=0, state=IDLE.
  - s1_weight=S1_INIT, s2_weight=S2_INIT.
  - Leak, refractory and window counters cleared; edge-detect registers cleared.
- Reset asserted mid-operation aborts everything immediately, including a pending FIRE or an open learning window.
- Spike events:
  - One event per rising edge of each input; a held-high input is a single spike.
  - Rising edge sampled at clock edge k → membrane updated at edge k+1 → state=FIRE and fire_out=1 after edge k+2, if the threshold was reached.
- Integration:
  - membrane += (e1 ? s1_weight : 0) + (e2 ? s2_weight : 0), zero-extended.
  - Saturates at 2^ACC_WIDTH-1.
  - Simultaneous N1 and N2 edges add both weights in the same cycle.
- Leak:
  - Free-running counter; every LEAK_PERIOD cycles, membrane -= membrane >> LEAK_SHIFT.
  - Leak coinciding with a spike: the leak is applied to the old value, then the weights are added.
- FSM:
  - IDLE → INTEG on any spike with a nonzero contribution.
  - INTEG → FIRE when membrane >= THRESHOLD.
  - INTEG → IDLE when the membrane leaks to 0.
  - FIRE: lasts exactly 1 cycle; fire_out=1, membrane cleared to 0, then → REFRACT.
  - REFRACT: counts REFRACTORY cycles, then → IDLE. Spikes arriving during FIRE or REFRACT do not integrate.
- Learning (S2 only):
  - An N2 edge (in any state) loads the window counter with COINC_WINDOW.
  - An N1 edge while window>0, or in the same cycle as the N2 edge, with learn_en=1 causes:
    - s2_weight += LEARN_STEP, saturating at 2^W_WIDTH-1;
    - the window is cleared, so there is at most one increment per N2 spike.
  - An N1 edge that precedes N2 does not learn.
  - A new N2 edge inside an open window reloads the window.
  - With learn_en=0, the window still runs but the weight is unchanged.
  - Weight update timing: visible on s2_weight the cycle after the N1 edge is sampled.
  - The same-cycle integration uses the old weight.

Decomposition:
- Package neuron_pkg:
  - state enum (IDLE/INTEG/FIRE/REFRACT);
  - W_WIDTH and ACC_WIDTH defaults;
  - saturating-add helper function.
- Sub-module hebbian_synapse, instantiated once for S2:
  - contains the weight register, coincidence-window counter and saturating increment;
  - inputs: pre/post edge pulses and learn_en; output: weight.
- S1 is a constant register in the top level.

Test Plan (sim overrides: LEAK_PERIOD=16, REFRACTORY=8, COINC_WINDOW=20):
- Reset: CPU_RESETN=0 → membrane=0, state=0, fire_out=0, s1_weight=FFF, s2_weight=000. Deassert; outputs hold.
- Single N1 rising edge at edge k → membrane=4095 after k+1; fire_out=1 for exactly one cycle after k+2; membrane=0; state=3 for 8 cycles, then 0. An N1 edge during REFRACT leaves membrane=0.
- N2 edge alone with s2_weight=0 → membrane stays 0, state stays IDLE, no fire_out.
- Conditioning:
  - learn_en=1, N2 edge then N1 edge 5 cycles later → s2_weight=0x100.
  - Repeat 16 times → s2_weight=0xFFF (clamped, not 0x000).
  - Then an N2 edge alone → membrane=4095, fire_out pulses.
  - N1 edge 25 cycles after N2 → no increment.
- Leak with S1_INIT=12'h400, single N1 edge → membrane=1024; after the next leak tick → 960; after the following tick → 900; no fire.
- Simultaneous N1 and N2 edges with s2_weight=FFF → membrane=8190 in one cycle; single fire_out. Assert CPU_RESETN=0 during REFRACT → state=0, membrane=0 immediately.
